// File: rtl/exhaustive_response_checker.sv
// Exhaustive-sweep response checker: compares a captured (vector, response) stream against
// a golden truth table and reports mismatch count, first failing vector and ordering errors.
module exhaustive_response_checker #(
    parameter int unsigned N_IN  = 6,
    parameter int unsigned CNT_W = 7
) (
    input  logic              CK,
    input  logic              reset,
    input  logic              gold_we,
    input  logic [N_IN-1:0]   gold_addr,
    input  logic              gold_data,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_pattern,
    input  logic              in_response,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic              first_fail_valid,
    output logic [N_IN-1:0]   first_fail_pattern,
    output logic              seq_error
);

    localparam int unsigned Depth = 2 ** N_IN;
    // Index is one bit wider than a vector so the terminal beat never aliases to 0.
    localparam logic [N_IN:0] LastIdx = (N_IN + 1)'(Depth - 1);

    typedef enum logic [1:0] {StIdle, StCheck, StDone} state_t;

    state_t            state_q, state_d;
    logic [Depth-1:0]  gold_q, gold_d;
    logic [N_IN:0]     exp_q, exp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ffv_q, ffv_d;
    logic [N_IN-1:0]   ffp_q, ffp_d;
    logic              seq_q, seq_d;
    logic              pass_q, pass_d;

    logic accept;
    logic mismatch;

    assign accept   = (state_q == StCheck) && in_valid;
    assign mismatch = in_response ^ gold_q[in_pattern];

    // Next-state and result update for table load, beat compare and run control.
    always_comb begin
        state_d = state_q;
        gold_d  = gold_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        ffv_d   = ffv_q;
        ffp_d   = ffp_q;
        seq_d   = seq_q;
        pass_d  = pass_q;
        case (state_q)
            StIdle: begin
                // Write commits on the same edge as start, so the first compare sees it.
                if (gold_we) gold_d[gold_addr] = gold_data;
                if (start) begin
                    state_d = StCheck;
                    exp_d   = '0;
                    cnt_d   = '0;
                    ffv_d   = 1'b0;
                    ffp_d   = '0;
                    seq_d   = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            StCheck: begin
                if (accept) begin
                    if (mismatch) begin
                        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
                        if (!ffv_q) begin
                            ffv_d = 1'b1;
                            ffp_d = in_pattern;
                        end
                    end
                    if ({1'b0, in_pattern} != exp_q) seq_d = 1'b1;
                    exp_d = exp_q + 1'b1;
                    if (exp_q == LastIdx) begin
                        state_d = StDone;
                        pass_d  = (cnt_d == '0) && !seq_d;
                    end
                end
            end
            StDone: begin
                // Table is retained across reruns; only reset clears it.
                if (start) begin
                    state_d = StCheck;
                    exp_d   = '0;
                    cnt_d   = '0;
                    ffv_d   = 1'b0;
                    ffp_d   = '0;
                    seq_d   = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge CK) begin
        if (reset) begin
            state_q <= StIdle;
            gold_q  <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
            ffv_q   <= 1'b0;
            ffp_q   <= '0;
            seq_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gold_q  <= gold_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            ffv_q   <= ffv_d;
            ffp_q   <= ffp_d;
            seq_q   <= seq_d;
            pass_q  <= pass_d;
        end
    end

    // Status outputs decode directly from registered state.
    assign in_ready           = (state_q == StCheck);
    assign busy               = (state_q == StCheck);
    assign done               = (state_q == StDone);
    assign pass               = pass_q;
    assign mismatch_count     = cnt_q;
    assign first_fail_valid   = ffv_q;
    assign first_fail_pattern = ffp_q;
    assign seq_error          = seq_q;

endmodule

// File: doc/exhaustive_response_checker.md
Name: exhaustive_response_checker

Overview:
- Consumes the (input vector, observed output) stream from an exhaustive-sweep run of a single-output gate-level benchmark.
- Compares each observed output against a golden truth table loaded beforehand.
- Reports mismatch count, the first failing vector and sequence errors, giving a pass/fail verdict for trojan detection.
- Acts as the reader/checker end of the stimulus-plus-capture flow that produces vectors 0..2^N_IN-1 in ascending order.

Parameters:
- N_IN, 6: number of benchmark inputs (vector width); the table holds 2^N_IN entries.
- CNT_W, 7: mismatch counter width; must be at least N_IN+1 so that the all-fail count fits.

Ports:
- CK  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- gold_we  in  1  golden-table write enable; honoured only in IDLE.
- gold_addr  in  N_IN  golden-table write address (the input vector).
- gold_data  in  1  expected output for gold_addr.
- start  in  1  one-cycle pulse that begins a check run; honoured in IDLE and DONE.
- in_valid  in  1  stream beat valid.
- in_ready  out  1  checker can accept a beat.
- in_pattern  in  N_IN  input vector applied to the DUT.
- in_response  in  1  observed DUT output for in_pattern.
- busy  out  1  high in CHECK.
- done  out  1  high in DONE.
- pass  out  1  verdict; meaningful only while done=1.
- mismatch_count  out  CNT_W  number of mismatching beats, saturating.
- first_fail_valid  out  1  at least one mismatch has been seen this run.
- first_fail_pattern  out  N_IN  in_pattern of the first mismatching beat.
- seq_error  out  1  sticky flag; some beat arrived out of ascending order.

Behaviour:
- Reset: state=IDLE; all outputs 0, including in_ready; all 2^N_IN golden-table bits cleared to 0; expected index=0. A reset during CHECK aborts the run with the same result.
- States are IDLE, CHECK and DONE. All outputs are registered.
- IDLE:
  - gold_we=1 writes gold_data to table[gold_addr] at the clock edge.
  - start=1 moves to CHECK. On that edge: clear mismatch_count, first_fail_*, seq_error, pass; set expected index to 0.
  - If gold_we and start are both high in the same cycle, the write commits; it is visible to the first compare.
- CHECK:
  - in_ready=1 and busy=1.
  - A beat is accepted on a clock edge where in_valid and in_ready are both 1.
  - mismatch = in_response XOR table[in_pattern].
  - On mismatch, mismatch_count increments, saturating at 2^CNT_W-1. On the first mismatch of the run only, latch first_fail_pattern and set first_fail_valid=1.
  - If in_pattern differs from the expected index, set seq_error. The compare still uses in_pattern, not the expected index.
  - The expected index increments on every accept.
  - The accept made while the expected index = 2^N_IN-1 transitions to DONE.
  - gold_we and start are ignored in CHECK.
  - No backpressure inside a run: in_valid gaps stall progress with no timeout.
- DONE:
  - in_ready=0, busy=0, done=1.
  - pass = (mismatch_count==0) AND NOT seq_error.
  - All results hold until start or reset. start re-enters CHECK with cleared results; the table is retained.
  - gold_we is ignored in DONE; reset returns to IDLE to reload the table.
- Latency:
  - The result registers reflect an accepted beat one cycle after the accepting edge.
  - done and pass rise on the cycle after the final accept.
  - Minimum run length is 2^N_IN accept cycles plus 1.
- Width rules:
  - The expected index is N_IN+1 bits wide internally, so the terminal accept is detected without aliasing to 0.
  - mismatch_count reaches 64 exactly for N_IN=6, CNT_W=7.

Test Plan:
1. Load table[v]=XOR of the bits of v for all 64 v; start; stream 0..63 with correct responses and no gaps -> done=1 one cycle after the 64th accept; pass=1; mismatch_count=0; first_fail_valid=0; seq_error=0.
2. Same as 1, but invert the response at vector 6'b101010 only -> mismatch_count=1, first_fail_valid=1, first_fail_pattern=6'b101010, pass=0.
3. Stream 0..5, then 5, then 7..63 (vector 6 omitted), all responses correct -> seq_error=1, mismatch_count=0, pass=0, done after 64 accepts.
4. Same as 1, with random in_valid gaps; pulse start and gold_we (gold_addr=0, gold_data=1) mid-run -> both ignored; results identical to scenario 1.
5. All 64 responses inverted -> mismatch_count=64, first_fail_pattern=6'b000000, pass=0.
6. Assert reset after 30 accepts -> next cycle all outputs 0, in_ready=0, table reads back all-zero. Reload, rerun, then pulse start in DONE -> second run gives identical results to scenario 1.
